// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, slave count, FSM state encoding and
// the one-hot slave-select helper used by the bridge and the interconnect.
package apb_pkg;

  localparam int APB_ADDR_W  = 20;
  localparam int APB_DATA_W  = 16;
  localparam int APB_STRB_W  = 2;
  localparam int APB_NUM_SLV = 2;

  // Address bit that selects between the two slaves.
  localparam int APB_SEL_BIT = APB_ADDR_W - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Address MSB to one-hot slave select.
  function automatic logic [APB_NUM_SLV-1:0] apb_sel_onehot(input logic msb);
    logic [APB_NUM_SLV-1:0] sel;
    sel = (msb == 1'b1) ? 2'b10 : 2'b01;
    return sel;
  endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command, response and APB signal bundle for apb_master_bridge.
// master = bridge view, slave = requester/APB-slave environment view.
interface apb_master_bridge_if import apb_pkg::*; #(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W,
  parameter int STRB_W = APB_STRB_W
);

  // Command channel
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_strb;

  // Response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  // APB requester side
  logic [APB_NUM_SLV-1:0] psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output psel, penable, paddr, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  psel, penable, paddr, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_slave_decode.sv
// Combinational slave decode: address MSB to one-hot psel.
module apb_slave_decode import apb_pkg::*; (
  input  logic                   addr_msb,
  output logic [APB_NUM_SLV-1:0] sel
);

  // Map the select bit onto a one-hot slave select
  always_comb begin
    sel = {APB_NUM_SLV{1'b0}};
    case (addr_msb)
      1'b0:    sel = apb_sel_onehot(1'b0);
      1'b1:    sel = apb_sel_onehot(1'b1);
      default: sel = {APB_NUM_SLV{1'b0}};
    endcase
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB4 requester. Turns a valid/ready command into
// SETUP/ACCESS phases, waits out pready wait states (bounded by a
// programmable timeout) and returns exactly one held response per command.
module apb_master_bridge import apb_pkg::*; #(
  parameter int          ADDR_W      = APB_ADDR_W,
  parameter int          DATA_W      = APB_DATA_W,
  parameter int          STRB_W      = APB_STRB_W,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  apb_master_bridge_if.master bus
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SETUP  = SETUP;
  localparam logic [1:0] ST_ACCESS = ACCESS;

  // Counter value seen on the last permitted ACCESS cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [1:0]             state_r;
  logic [7:0]             tmo_cnt_r;
  logic [APB_NUM_SLV-1:0] psel_r;
  logic                   penable_r;
  logic [ADDR_W-1:0]      paddr_r;
  logic                   pwrite_r;
  logic [DATA_W-1:0]      pwdata_r;
  logic [STRB_W-1:0]      pstrb_r;
  logic                   rsp_valid_r;
  logic [DATA_W-1:0]      rsp_rdata_r;
  logic                   rsp_err_r;
  logic                   rsp_timeout_r;

  logic [APB_NUM_SLV-1:0] sel_s;
  logic                   req_ready_s;
  logic                   accept_s;

  apb_slave_decode u_decode (
    .addr_msb (bus.req_addr[ADDR_W-1]),
    .sel      (sel_s)
  );

  // Accept only when idle, no response is pending and reset is released
  always_comb begin
    req_ready_s = 1'b0;
    if (reset_n && (state_r == ST_IDLE) && !rsp_valid_r) begin
      req_ready_s = 1'b1;
    end else begin
      req_ready_s = 1'b0;
    end
  end

  assign accept_s = bus.req_valid && req_ready_s;

  // FSM, APB output registers, timeout counter and response register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      tmo_cnt_r     <= 8'd0;
      psel_r        <= {APB_NUM_SLV{1'b0}};
      penable_r     <= 1'b0;
      paddr_r       <= {ADDR_W{1'b0}};
      pwrite_r      <= 1'b0;
      pwdata_r      <= {DATA_W{1'b0}};
      pstrb_r       <= {STRB_W{1'b0}};
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= {DATA_W{1'b0}};
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            psel_r    <= sel_s;
            paddr_r   <= bus.req_addr;
            pwrite_r  <= bus.req_write;
            pwdata_r  <= bus.req_write ? bus.req_wdata : {DATA_W{1'b0}};
            pstrb_r   <= bus.req_write ? bus.req_strb  : {STRB_W{1'b0}};
            tmo_cnt_r <= 8'd0;
            state_r   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_r <= 1'b1;
          state_r   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (bus.pready || (tmo_cnt_r == TMO_LAST)) begin
            // Completion or abort: release the bus and post the response
            state_r       <= ST_IDLE;
            psel_r        <= {APB_NUM_SLV{1'b0}};
            penable_r     <= 1'b0;
            paddr_r       <= {ADDR_W{1'b0}};
            pwrite_r      <= 1'b0;
            pwdata_r      <= {DATA_W{1'b0}};
            pstrb_r       <= {STRB_W{1'b0}};
            rsp_valid_r   <= 1'b1;
            rsp_err_r     <= bus.pready ? bus.pslverr : 1'b1;
            rsp_timeout_r <= !bus.pready;
            rsp_rdata_r   <= (bus.pready && !pwrite_r) ? bus.prdata : {DATA_W{1'b0}};
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          psel_r    <= {APB_NUM_SLV{1'b0}};
          penable_r <= 1'b0;
        end
      endcase
      // A response only exists while idle, so consumption never races completion
      if (rsp_valid_r && bus.rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

  assign bus.req_ready   = req_ready_s;
  assign bus.psel        = psel_r;
  assign bus.penable     = penable_r;
  assign bus.paddr       = paddr_r;
  assign bus.pwrite      = pwrite_r;
  assign bus.pwdata      = pwdata_r;
  assign bus.pstrb       = pstrb_r;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_rdata   = rsp_rdata_r;
  assign bus.rsp_err     = rsp_err_r;
  assign bus.rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge (TIMEOUT_CYC = 4).
module tb_apb_master_bridge;
  import apb_pkg::*;

  logic clk;
  logic reset_n;
  int   chk_cnt;
  int   pass_cnt;

  apb_master_bridge_if bus ();

  apb_master_bridge #(
    .ADDR_W      (20),
    .DATA_W      (16),
    .STRB_W      (2),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    if (obs === exp) begin
      pass_cnt = pass_cnt + 1;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a command, wait (bounded) for acceptance; returns at the
  // negedge after the accepting edge, i.e. during SETUP.
  task automatic issue(input logic wr, input logic [19:0] addr,
                       input logic [15:0] wdata, input logic [1:0] strb);
    int waited;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_strb  = strb;
    waited = 0;
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited = waited + 1;
    end
    check_val("accept_wait", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Consume the pending response in one cycle
  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_val("rsp_cleared", {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    chk_cnt = 0;
    pass_cnt = 0;
    reset_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 20'h0;
    bus.req_wdata = 16'h0;
    bus.req_strb  = 2'b00;
    bus.rsp_ready = 1'b0;
    bus.prdata    = 16'h0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_val("rst_psel", {30'd0, bus.psel}, 32'd0);
    check_val("rst_penable", {31'd0, bus.penable}, 32'd0);
    check_val("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check_val("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    reset_n = 1'b1;
    #1;
    check_val("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // 1: zero-wait write to slave 0
    bus.pready = 1'b1;
    issue(1'b1, 20'h00010, 16'hBEEF, 2'b11);
    check_val("t1_setup_psel", {30'd0, bus.psel}, 32'd1);
    check_val("t1_setup_penable", {31'd0, bus.penable}, 32'd0);
    check_val("t1_paddr", {12'd0, bus.paddr}, 32'h00010);
    check_val("t1_pwrite", {31'd0, bus.pwrite}, 32'd1);
    check_val("t1_pwdata", {16'd0, bus.pwdata}, 32'hBEEF);
    check_val("t1_pstrb", {30'd0, bus.pstrb}, 32'd3);
    check_val("t1_busy_ready", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    check_val("t1_access_penable", {31'd0, bus.penable}, 32'd1);
    check_val("t1_access_psel", {30'd0, bus.psel}, 32'd1);
    @(negedge clk);
    check_val("t1_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check_val("t1_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check_val("t1_rsp_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
    check_val("t1_done_psel", {30'd0, bus.psel}, 32'd0);
    check_val("t1_done_paddr", {12'd0, bus.paddr}, 32'd0);
    check_val("t1_done_penable", {31'd0, bus.penable}, 32'd0);
    consume();

    // 2: read slave 1, 3 wait states (completes on the 4th = last allowed cycle),
    // pslverr toggles while not ready and must be ignored
    bus.pready = 1'b0;
    bus.pslverr = 1'b1;
    issue(1'b0, 20'h80004, 16'h1234, 2'b11);
    check_val("t2_psel", {30'd0, bus.psel}, 32'd2);
    check_val("t2_pwdata_zero", {16'd0, bus.pwdata}, 32'd0);
    check_val("t2_pstrb_zero", {30'd0, bus.pstrb}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("t2_penable", {31'd0, bus.penable}, 32'd1);
      check_val("t2_paddr", {12'd0, bus.paddr}, 32'h80004);
      check_val("t2_pwrite", {31'd0, bus.pwrite}, 32'd0);
      bus.pslverr = ~bus.pslverr;
      if (i == 3) begin
        bus.pready = 1'b1;
        bus.pslverr = 1'b0;
        bus.prdata = 16'hABCD;
      end
    end
    @(negedge clk);
    bus.pready = 1'b0;
    check_val("t2_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check_val("t2_rsp_rdata", {16'd0, bus.rsp_rdata}, 32'hABCD);
    check_val("t2_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check_val("t2_rsp_timeout", {31'd0, bus.rsp_timeout}, 32'd0);
    consume();

    // 3: read with slave error on the completing cycle
    bus.pslverr = 1'b1;
    issue(1'b0, 20'h00020, 16'h0000, 2'b00);
    @(negedge clk);
    bus.pslverr = 1'b0;
    @(negedge clk);
    bus.pready = 1'b1;
    bus.pslverr = 1'b1;
    bus.prdata = 16'h5555;
    @(negedge clk);
    bus.pready = 1'b0;
    bus.pslverr = 1'b0;
    check_val("t3_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check_val("t3_rsp_err", {31'd0, bus.rsp_err}, 32'd1);
    check_val("t3_rsp_timeout", {31'd0, bus.rsp_timeout}, 32'd0);
    check_val("t3_rsp_rdata", {16'd0, bus.rsp_rdata}, 32'h5555);
    consume();

    // 4: slave never ready -> abort after exactly 4 ACCESS cycles
    bus.prdata = 16'hFFFF;
    issue(1'b0, 20'h80000, 16'h0000, 2'b00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("t4_access_penable", {31'd0, bus.penable}, 32'd1);
      check_val("t4_access_psel", {30'd0, bus.psel}, 32'd2);
    end
    @(negedge clk);
    check_val("t4_abort_psel", {30'd0, bus.psel}, 32'd0);
    check_val("t4_abort_penable", {31'd0, bus.penable}, 32'd0);
    check_val("t4_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check_val("t4_rsp_err", {31'd0, bus.rsp_err}, 32'd1);
    check_val("t4_rsp_timeout", {31'd0, bus.rsp_timeout}, 32'd1);
    check_val("t4_rsp_rdata", {16'd0, bus.rsp_rdata}, 32'd0);

    // 5: backpressure on the pending timeout response
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 20'h00008;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("t5_req_ready", {31'd0, bus.req_ready}, 32'd0);
      check_val("t5_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check_val("t5_rsp_timeout", {31'd0, bus.rsp_timeout}, 32'd1);
      check_val("t5_no_psel", {30'd0, bus.psel}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_val("t5_consumed", {31'd0, bus.rsp_valid}, 32'd0);
    check_val("t5_fields_kept", {30'd0, bus.rsp_err, bus.rsp_timeout}, 32'd3);
    check_val("t5_not_yet_psel", {30'd0, bus.psel}, 32'd0);
    check_val("t5_ready_again", {31'd0, bus.req_ready}, 32'd1);
    bus.pready = 1'b1;
    bus.prdata = 16'h0F0F;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_val("t5_setup_psel", {30'd0, bus.psel}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check_val("t5_rsp_rdata", {16'd0, bus.rsp_rdata}, 32'h0F0F);
    check_val("t5_rsp_timeout_clr", {31'd0, bus.rsp_timeout}, 32'd0);
    consume();

    // 6: reset during ACCESS drops the transfer
    bus.pready = 1'b0;
    issue(1'b1, 20'h00040, 16'h1111, 2'b01);
    @(negedge clk);
    check_val("t6_in_access", {31'd0, bus.penable}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_val("t6_psel", {30'd0, bus.psel}, 32'd0);
    check_val("t6_penable", {31'd0, bus.penable}, 32'd0);
    check_val("t6_paddr", {12'd0, bus.paddr}, 32'd0);
    check_val("t6_pwrite", {31'd0, bus.pwrite}, 32'd0);
    check_val("t6_pwdata", {16'd0, bus.pwdata}, 32'd0);
    check_val("t6_pstrb", {30'd0, bus.pstrb}, 32'd0);
    check_val("t6_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check_val("t6_req_ready", {31'd0, bus.req_ready}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("t6_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    bus.pready = 1'b1;
    bus.prdata = 16'h1357;
    issue(1'b0, 20'h80010, 16'h0000, 2'b00);
    @(negedge clk);
    @(negedge clk);
    check_val("t6_rd_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check_val("t6_rd_rdata", {16'd0, bus.rsp_rdata}, 32'h1357);
    check_val("t6_rd_err", {31'd0, bus.rsp_err}, 32'd0);
    consume();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
